// File: rtl/token_grouper.sv
// Token grouper: walks a DELIM-separated word list in input memory, looks each word up in a
// vocab list, and copies matched (mode=0) or unmatched (mode=1) words to output memory.
module token_grouper #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] vocab_base,
  input  logic [ADDR_WIDTH-1:0] vocab_end,
  output logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_we,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic [ADDR_WIDTH-1:0] match_count
);

  localparam logic [ADDR_WIDTH-1:0] AMAX = '1;

  typedef enum logic [2:0] {IDLE, FETCH, CMP, VSKIP, COPY, TERM, FIN} state_t;

  // start is a level qualifier, not a handshake: it is acted on only in a cycle where the
  // FSM is IDLE; busy rises the next cycle and done pulses once when the pass completes.
  state_t                  state_q, state_d;
  logic                    data_ph_q, data_ph_d;       // 0: address issued, 1: read data valid
  logic                    skip_chk_q, skip_chk_d;     // VSKIP: 0 scanning, 1 testing entry head
  logic                    write_pass_q, write_pass_d; // COPY: 0 measuring, 1 writing
  logic                    do_copy_q, do_copy_d;
  logic                    mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   vbase_q, vbase_d, vend_q, vend_d;
  logic [ADDR_WIDTH-1:0]   in_ptr_q, in_ptr_d, ia_q, ia_d, va_q, va_d, out_ptr_q, out_ptr_d;
  logic [ADDR_WIDTH-1:0]   wcnt_q, wcnt_d, mcnt_q, mcnt_d;
  logic                    ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0]   ich;
  logic [ADDR_WIDTH-1:0]   next_word;
  logic [ADDR_WIDTH:0]     fit_sum;
  logic                    fits;

  function automatic logic [ADDR_WIDTH-1:0] sat_inc(input logic [ADDR_WIDTH-1:0] v);
    return (v == AMAX) ? v : v + 1'b1;
  endfunction

  // The all-ones input address is never read as data: it always ends the current word/list.
  assign ich       = (ia_q == AMAX) ? DELIM : in_data;
  assign next_word = (ia_q == AMAX) ? AMAX : ia_q + 1'b1;
  // Word of length L at out_ptr needs L chars + DELIM and leaves all-ones for the terminator.
  assign fit_sum   = {1'b0, out_ptr_q} + {1'b0, ia_q - in_ptr_q};
  assign fits      = fit_sum < {1'b0, AMAX};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_ph_q    <= 1'b0;
      skip_chk_q   <= 1'b0;
      write_pass_q <= 1'b0;
      do_copy_q    <= 1'b0;
      mode_q       <= 1'b0;
      vbase_q      <= '0;
      vend_q       <= '0;
      in_ptr_q     <= '0;
      ia_q         <= '0;
      va_q         <= '0;
      out_ptr_q    <= '0;
      wcnt_q       <= '0;
      mcnt_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_ph_q    <= data_ph_d;
      skip_chk_q   <= skip_chk_d;
      write_pass_q <= write_pass_d;
      do_copy_q    <= do_copy_d;
      mode_q       <= mode_d;
      vbase_q      <= vbase_d;
      vend_q       <= vend_d;
      in_ptr_q     <= in_ptr_d;
      ia_q         <= ia_d;
      va_q         <= va_d;
      out_ptr_q    <= out_ptr_d;
      wcnt_q       <= wcnt_d;
      mcnt_q       <= mcnt_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_ph_d    = data_ph_q;
    skip_chk_d   = skip_chk_q;
    write_pass_d = write_pass_q;
    do_copy_d    = do_copy_q;
    mode_d       = mode_q;
    vbase_d      = vbase_q;
    vend_d       = vend_q;
    in_ptr_d     = in_ptr_q;
    ia_d         = ia_q;
    va_d         = va_q;
    out_ptr_d    = out_ptr_q;
    wcnt_d       = wcnt_q;
    mcnt_d       = mcnt_q;
    ovf_d        = ovf_q;
    out_we       = 1'b0;
    out_data     = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          data_ph_d = 1'b0;
          mode_d    = mode;
          vbase_d   = vocab_base;
          vend_d    = vocab_end;
          in_ptr_d  = '0;
          ia_d      = '0;
          out_ptr_d = '0;
          wcnt_d    = '0;
          mcnt_d    = '0;
          ovf_d     = 1'b0;
        end
      end
      FETCH: begin
        if (!data_ph_q) data_ph_d = 1'b1;
        else if (ich == DELIM) state_d = TERM;
        else begin
          wcnt_d    = sat_inc(wcnt_q);
          va_d      = vbase_q;
          data_ph_d = 1'b0;
          state_d   = CMP;
        end
      end
      CMP: begin
        if (!data_ph_q) data_ph_d = 1'b1;
        else begin
          data_ph_d = 1'b0;
          if (va_q > vend_q || ich != voc_data) begin
            state_d    = VSKIP;
            skip_chk_d = 1'b0;
          end else if (ich == DELIM) begin
            mcnt_d       = sat_inc(mcnt_q);
            do_copy_d    = ~mode_q;
            write_pass_d = 1'b0;
            ia_d         = in_ptr_q;
            state_d      = COPY;
          end else if (va_q == vend_q) begin
            state_d    = VSKIP;
            skip_chk_d = 1'b0;
          end else begin
            ia_d = ia_q + 1'b1;
            va_d = va_q + 1'b1;
          end
        end
      end
      VSKIP: begin
        if (!data_ph_q) data_ph_d = 1'b1;
        else begin
          data_ph_d = 1'b0;
          if ((!skip_chk_q && va_q >= vend_q) || (skip_chk_q && voc_data == DELIM)) begin
            // vocab exhausted: the word is unmatched
            do_copy_d    = mode_q;
            write_pass_d = 1'b0;
            ia_d         = in_ptr_q;
            state_d      = COPY;
          end else if (!skip_chk_q) begin
            va_d = va_q + 1'b1;
            if (voc_data == DELIM) skip_chk_d = 1'b1;
          end else begin
            skip_chk_d = 1'b0;
            ia_d       = in_ptr_q;
            state_d    = CMP;
          end
        end
      end
      COPY: begin
        if (!data_ph_q) data_ph_d = 1'b1;
        else begin
          data_ph_d = 1'b0;
          if (write_pass_q) begin
            out_we    = 1'b1;
            out_data  = ich;
            out_ptr_d = out_ptr_q + 1'b1;
            if (ich == DELIM) begin
              in_ptr_d = next_word;
              ia_d     = next_word;
              state_d  = FETCH;
            end else begin
              ia_d = ia_q + 1'b1;
            end
          end else if (ich != DELIM) begin
            ia_d = ia_q + 1'b1;
          end else if (!do_copy_q) begin
            in_ptr_d = next_word;
            ia_d     = next_word;
            state_d  = FETCH;
          end else if (fits) begin
            write_pass_d = 1'b1;
            ia_d         = in_ptr_q;
          end else begin
            ovf_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      TERM: begin
        out_we   = 1'b1;
        out_data = DELIM;
        state_d  = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_addr     = ia_q;
  assign voc_addr    = va_q;
  assign out_addr    = out_ptr_q;
  assign busy        = (state_q != IDLE) && (state_q != FIN);
  assign done        = (state_q == FIN);
  assign overflow    = ovf_q;
  assign word_count  = wcnt_q;
  assign match_count = mcnt_q;

endmodule

// File: tb/tb_token_grouper.sv
// Directed bench for token_grouper: an 8-bit-address instance for functional cases and a
// 4-bit-address instance for output exhaustion. Memories are modelled as synchronous-read.
module tb_token_grouper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, mode8, out_we8, busy8, done8, ovf8;
  logic [7:0] vbase8, vend8, in_addr8, voc_addr8, out_addr8, wc8, mc8;
  logic [7:0] in_data8, voc_data8, out_data8;

  logic       start4, mode4, out_we4, busy4, done4, ovf4;
  logic [3:0] vbase4, vend4, in_addr4, voc_addr4, out_addr4, wc4, mc4;
  logic [7:0] in_data4, voc_data4, out_data4;

  logic [7:0]  in_mem8[256];
  logic [7:0]  voc_mem8[256];
  logic [7:0]  in_mem4[16];
  logic [7:0]  voc_mem4[16];
  logic [15:0] wlog8[$];
  logic [15:0] wlog4[$];
  int          done_cnt8 = 0;
  int          done_cnt4 = 0;
  int          total;
  int          bad;

  token_grouper #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DELIM(8'h00)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
    .vocab_base(vbase8), .vocab_end(vend8),
    .in_addr(in_addr8), .in_data(in_data8), .voc_addr(voc_addr8), .voc_data(voc_data8),
    .out_addr(out_addr8), .out_data(out_data8), .out_we(out_we8),
    .busy(busy8), .done(done8), .overflow(ovf8), .word_count(wc8), .match_count(mc8)
  );

  token_grouper #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DELIM(8'h00)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4),
    .vocab_base(vbase4), .vocab_end(vend4),
    .in_addr(in_addr4), .in_data(in_data4), .voc_addr(voc_addr4), .voc_data(voc_data4),
    .out_addr(out_addr4), .out_data(out_data4), .out_we(out_we4),
    .busy(busy4), .done(done4), .overflow(ovf4), .word_count(wc4), .match_count(mc4)
  );

  always @(posedge clk) begin
    in_data8  <= in_mem8[in_addr8];
    voc_data8 <= voc_mem8[voc_addr8];
    in_data4  <= in_mem4[in_addr4];
    voc_data4 <= voc_mem4[voc_addr4];
    if (out_we8) wlog8.push_back({out_addr8, out_data8});
    if (out_we4) wlog4.push_back({4'h0, out_addr4, out_data4});
  end

  always @(negedge clk) begin
    if (done8) done_cnt8 <= done_cnt8 + 1;
    if (done4) done_cnt4 <= done_cnt4 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // '.' in a string stands for the DELIM character; unused locations hold a non-DELIM filler.
  task automatic load(input bit w4, input bit voc, input string s);
    for (int i = 0; i < (w4 ? 16 : 256); i++) begin
      logic [7:0] c;
      c = (i < s.len()) ? ((s[i] == ".") ? 8'h00 : s[i]) : 8'h7E;
      if (w4) begin
        if (voc) voc_mem4[i] = c; else in_mem4[i] = c;
      end else begin
        if (voc) voc_mem8[i] = c; else in_mem8[i] = c;
      end
    end
  endtask

  task automatic run(input bit w4, input bit m, input logic [7:0] vb, input logic [7:0] ve,
                     input bit poke, output int cyc);
    bit got;
    int d0;
    got = 1'b0;
    cyc = 0;
    d0  = w4 ? done_cnt4 : done_cnt8;
    @(negedge clk);
    if (w4) begin
      start4 = 1'b1; mode4 = m; vbase4 = vb[3:0]; vend4 = ve[3:0];
    end else begin
      start8 = 1'b1; mode8 = m; vbase8 = vb; vend8 = ve;
    end
    while (!got && cyc < 4000) begin
      @(negedge clk);
      start8 = 1'b0;
      start4 = 1'b0;
      cyc++;
      if (poke && cyc == 5) begin
        start8 = 1'b1; mode8 = ~m; vbase8 = 8'h40; vend8 = 8'h00;
      end
      if (w4 ? done4 : done8) got = 1'b1;
    end
    chk("done_seen", got, 1);
    repeat (3) @(negedge clk);
    chk("done_pulses", (w4 ? done_cnt4 : done_cnt8) - d0, 1);
    chk("busy_after", w4 ? busy4 : busy8, 0);
  endtask

  task automatic check_out(input bit w4, input int base, input string exp);
    int n;
    n = w4 ? wlog4.size() : wlog8.size();
    chk("write_count", n - base, exp.len());
    for (int i = 0; i < exp.len() && base + i < n; i++) begin
      logic [15:0] e;
      logic [15:0] g;
      e = {8'(i), (exp[i] == ".") ? 8'h00 : exp[i]};
      g = w4 ? wlog4[base + i] : wlog8[base + i];
      chk($sformatf("write_%0d", i), g, e);
    end
  endtask

  initial begin
    int  cyc;
    int  b8;
    int  b4;
    int  nlog;
    bit  seen;
    total = 0; bad = 0;
    rst_n = 1'b0;
    start8 = 1'b0; mode8 = 1'b0; vbase8 = '0; vend8 = '0;
    start4 = 1'b0; mode4 = 1'b0; vbase4 = '0; vend4 = '0;
    load(0, 1, "ab.cd..");
    load(0, 0, "cd.xy..");
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_we", out_we8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_wc", wc8, 0);
    chk("rst_mc", mc8, 0);
    chk("rst_addrs", {in_addr8, voc_addr8, out_addr8}, 0);
    chk("rst_out_data", out_data8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // matched words copied
    b8 = wlog8.size();
    run(0, 0, 8'd0, 8'd6, 0, cyc);
    check_out(0, b8, "cd..");
    chk("m0_wc", wc8, 2);
    chk("m0_mc", mc8, 1);
    chk("m0_ovf", ovf8, 0);

    // unmatched words copied
    b8 = wlog8.size();
    run(0, 1, 8'd0, 8'd6, 0, cyc);
    check_out(0, b8, "xy..");
    chk("m1_wc", wc8, 2);
    chk("m1_mc", mc8, 1);

    // start and configuration changes while busy have no effect
    b8 = wlog8.size();
    run(0, 0, 8'd0, 8'd6, 1, cyc);
    check_out(0, b8, "cd..");
    chk("poke_mc", mc8, 1);

    // prefix and extension of a vocab entry do not match
    load(0, 1, "abc..");
    load(0, 0, "ab.abcd..");
    b8 = wlog8.size();
    run(0, 0, 8'd0, 8'd4, 0, cyc);
    check_out(0, b8, ".");
    chk("prefix_wc", wc8, 2);
    chk("prefix_mc", mc8, 0);

    // empty input list
    load(0, 0, ".");
    b8 = wlog8.size();
    run(0, 0, 8'd0, 8'd4, 0, cyc);
    check_out(0, b8, ".");
    chk("empty_wc", wc8, 0);
    chk("empty_latency", cyc <= 4, 1);

    // vocab_end excludes the entry that would match
    load(0, 1, "ab.cd..");
    load(0, 0, "cd..");
    b8 = wlog8.size();
    run(0, 0, 8'd0, 8'd2, 0, cyc);
    check_out(0, b8, ".");
    chk("vend_wc", wc8, 1);
    chk("vend_mc", mc8, 0);

    // vocab_base skips the first entry
    load(0, 0, "cd.ab..");
    b8 = wlog8.size();
    run(0, 0, 8'd3, 8'd6, 0, cyc);
    check_out(0, b8, "cd..");
    chk("vbase_wc", wc8, 2);
    chk("vbase_mc", mc8, 1);

    // reset while copying aborts, then a fresh pass reproduces the first result
    load(0, 0, "cd.xy..");
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; vbase8 = 8'd0; vend8 = 8'd6;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (out_we8) seen = 1'b1;
    end
    chk("copy_reached", seen, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", out_we8, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_wc", wc8, 0);
    nlog = wlog8.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_write", wlog8.size() - nlog, 0);
    b8 = wlog8.size();
    run(0, 0, 8'd0, 8'd6, 0, cyc);
    check_out(0, b8, "cd..");
    chk("rerun_wc", wc8, 2);
    chk("rerun_mc", mc8, 1);

    // 4-bit addresses: third word cannot fit with its DELIM plus the terminator
    load(1, 1, "abcde.abc..");
    load(1, 0, "abcde.abcde.abc.");
    b4 = wlog4.size();
    run(1, 0, 8'd0, 8'd10, 0, cyc);
    check_out(1, b4, "abcde.abcde.");
    chk("ovf_flag", ovf4, 1);
    chk("ovf_wc", wc4, 3);
    chk("ovf_mc", mc4, 3);
    repeat (4) @(negedge clk);
    chk("ovf_sticky", ovf4, 1);

    // next start clears overflow
    load(1, 0, "abc..");
    b4 = wlog4.size();
    run(1, 0, 8'd0, 8'd10, 0, cyc);
    check_out(1, b4, "abc..");
    chk("clr_ovf", ovf4, 0);
    chk("clr_wc", wc4, 1);
    chk("clr_mc", mc4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
